// File: rtl/uart_send.sv
// UART transmitter: 8N1 frames with an optional parity bit, started by a rising
// edge on send_en and reported through tx_busy and a one-cycle tx_done pulse.
module uart_send #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       send_en,
    input  logic [7:0] send_data,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic             en_d0_q, en_d0_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             done_q, done_d;

    logic start_flag;
    logic bit_end;
    logic parity_bit;

    assign start_flag = send_en & ~en_d0_q;
    assign bit_end    = (baud_cnt_q == CNT_MAX);
    assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);

    always_comb begin
        state_d    = state_q;
        en_d0_d    = send_en;
        data_d     = data_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = 1'b0;

        // Counters only run inside a frame; IDLE holds them at zero.
        if (state_q != IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_flag) begin
                    data_d     = send_data;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            en_d0_q    <= 1'b0;
            data_q     <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_d0_q    <= en_d0_d;
            data_q     <= data_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        uart_txd = 1'b1;
        case (state_q)
            START:   uart_txd = 1'b0;
            DATA:    uart_txd = data_q[bit_cnt_q];
            PARITY:  uart_txd = parity_bit;
            default: uart_txd = 1'b1;
        endcase
    end

    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;

endmodule

// File: doc/uart_send.md
UART_SEND -- requirements
Module: uart_send

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, line baud rate.
REQ-003 Parameter PARITY_EN, default 0, 1 inserts a parity bit after D7.
REQ-004 Parameter PARITY_ODD, default 0, 0 selects even parity and 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 sys_clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 sys_rst  input  1  synchronous, active-high reset.
REQ-007 send_en  input  1  transmit request; a rising edge starts one frame, and the level may stay high indefinitely.
REQ-008 send_data  input  8  byte to send; sampled in the cycle the send_en rising edge is detected.
REQ-009 uart_txd  output  1  serial line, idle high.
REQ-010 tx_busy  output  1  high while a frame is in progress.
REQ-011 tx_done  output  1  one-cycle pulse when a frame's stop bit completes.

Function
REQ-012 BPS_CNT SHALL equal CLK_FREQ/UART_BPS with integer truncation, and every bit period SHALL last exactly BPS_CNT cycles.
REQ-013 The block SHALL keep en_d0, which is send_en registered once; start_flag = send_en & ~en_d0.
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: uart_txd=1 and tx_busy=0; start_flag=1 SHALL latch send_data, clear the baud and bit counters, and enter START at the next edge.
REQ-016 Latency: uart_txd=0 and tx_busy=1 SHALL appear on the first edge after the cycle in which start_flag=1.
REQ-017 START: uart_txd=0 for BPS_CNT cycles, then enter DATA.
REQ-018 DATA: the latched bits SHALL be sent LSB first, D0..D7, each for BPS_CNT cycles; the 3-bit bit counter wraps 7->0 on exit; after D7 the next state is PARITY if PARITY_EN=1, otherwise STOP.
REQ-019 PARITY: uart_txd = XOR of the latched byte XOR PARITY_ODD, held for BPS_CNT cycles, then enter STOP.
REQ-020 STOP: uart_txd=1 for BPS_CNT cycles, then enter IDLE.
REQ-021 On the STOP-to-IDLE transition edge, tx_busy SHALL fall and tx_done SHALL pulse high for exactly one cycle.
REQ-022 Frame length from the first start-bit cycle to tx_busy falling SHALL be exactly (10+PARITY_EN)*BPS_CNT cycles.
REQ-023 The baud counter SHALL count 0..BPS_CNT-1 and wrap to 0 at each bit boundary; it SHALL be wide enough for BPS_CNT-1 with no overflow.
REQ-024 Any start_flag while tx_busy=1 SHALL be ignored: no queueing, and the latched byte is unchanged.
REQ-025 A send_en level held high across the end of a frame SHALL NOT start a new frame; only a fresh 0->1 transition does.
REQ-026 start_flag in the same cycle tx_done pulses (first IDLE cycle) SHALL be accepted; back-to-back frames have zero idle cycles beyond that one.
REQ-027 Changes to send_data after capture SHALL NOT affect the frame in progress.

Reset
REQ-028 With sys_rst=1 at a clock edge: state=IDLE, uart_txd=1, tx_busy=0, tx_done=0, en_d0=0, counters=0, and the latched byte=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame at the next edge: uart_txd=1, and no tx_done pulse is produced.
REQ-030 If send_en is already high when reset releases, the first cycle after release SHALL see start_flag=1 and start a frame, since en_d0 was reset to 0.

Verification
REQ-031 Use CLK_FREQ=1600 and UART_BPS=100 (BPS_CNT=16); send_en 0->1 with send_data=8'hA5 -> txd 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles; tx_busy high 160 cycles; one tx_done pulse.
REQ-032 PARITY_EN=1, PARITY_ODD=0, data=8'h07 -> parity bit=1, frame 176 cycles; with PARITY_ODD=1 -> parity bit=0.
REQ-033 Hold send_en high through a frame, then a new rising edge with data 8'h3C 40 cycles into the frame -> 8'h3C is never sent and tx_busy does not extend; a later 0->1 edge after tx_done sends 8'h3C.
REQ-034 Rising edge aligned with the tx_done cycle -> the next start bit begins on the following edge and tx_busy falls for only that one cycle.
REQ-035 Assert sys_rst at cycle 50 of a frame -> txd=1, tx_busy=0 on the next edge, no tx_done, and a fresh request afterward sends a correct frame.
REQ-036 Default parameters (BPS_CNT=434), data=8'h55 -> each bit measures 434 cycles and the frame measures 4340 cycles.
